// File: rtl/int_controller.sv
// Priority interrupt controller for CP0.HWInt: edge/level capture, per-source enable, one source in service until EOI.
// Optional macro INT_CTRL_SYNC_EN puts a two-flop synchronizer on src_in (src->pend latency +2 clk).
module int_controller #(
  parameter int NSRC     = 6,
  parameter int DEV_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_in,
  input  logic            int_taken,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hwint_out,
  output logic            irq_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  localparam logic [1:0]      BASE    = 2'(DEV_ADDR);
  localparam logic [1:0]      SEL_PND = 2'd0;
  localparam logic [1:0]      SEL_EN  = 2'd1;
  localparam logic [1:0]      SEL_MOD = 2'd2;
  localparam logic [1:0]      SEL_STS = 2'd3;
  localparam logic [NSRC-1:0] ONE     = {{(NSRC-1){1'b0}}, 1'b1};

  state_t          r_state, w_state_nxt;
  logic [NSRC-1:0] r_s, r_s_d, r_pend, r_enable, r_mode, r_hwint;
  logic [2:0]      r_active_id;

  logic [NSRC-1:0] w_src, w_req, w_win_oh, w_clr, w_pend_nxt, w_hwint_nxt;
  logic [2:0]      w_win_id;
  logic            w_has_win, w_take;
  logic [1:0]      w_sel;
  logic            w_wr_pend, w_wr_en, w_wr_mode, w_eoi;
  logic            w_unused;

`ifdef INT_CTRL_SYNC_EN
  logic [NSRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = src_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s   <= '0;
      r_s_d <= '0;
    end else begin
      r_s   <= w_src;
      r_s_d <= r_s;
    end
  end

  assign w_sel     = addr[3:2] - BASE;
  assign w_wr_pend = we && (w_sel == SEL_PND);
  assign w_wr_en   = we && (w_sel == SEL_EN);
  assign w_wr_mode = we && (w_sel == SEL_MOD);
  assign w_eoi     = we && (w_sel == SEL_STS);

  // Lowest index wins; scan downward so the last hit is the lowest.
  assign w_req = r_pend & r_enable;
  always_comb begin
    w_has_win = 1'b0;
    w_win_id  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_has_win = 1'b1;
        w_win_id  = 3'(i);
      end
    end
  end
  assign w_win_oh = w_has_win ? (ONE << w_win_id) : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_has_win) w_state_nxt = REQ;
      REQ: begin
        if (!w_has_win)     w_state_nxt = IDLE;
        else if (int_taken) w_state_nxt = SERVICE;
      end
      SERVICE: if (w_eoi) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (hwint is registered, so these feed its D input)
  always_comb begin
    w_take      = 1'b0;
    w_hwint_nxt = '0;
    if (r_state == REQ && w_has_win) begin
      if (int_taken) w_take      = 1'b1;
      else           w_hwint_nxt = w_win_oh;
    end
  end

  // Set beats clear on edge bits; level bits simply follow s.
  assign w_clr      = ({NSRC{w_wr_pend}} & wdata[NSRC-1:0]) | ({NSRC{w_take}} & w_win_oh);
  assign w_pend_nxt = (r_mode & ((r_pend & ~w_clr) | (r_s & ~r_s_d))) | (~r_mode & r_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_hwint     <= '0;
      r_active_id <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_hwint <= w_hwint_nxt;
      if (w_wr_en)   r_enable    <= wdata[NSRC-1:0];
      if (w_wr_mode) r_mode      <= wdata[NSRC-1:0];
      if (w_take)    r_active_id <= w_win_id;
    end
  end

  always_comb begin
    rdata = '0;
    case (w_sel)
      SEL_PND: rdata = {{(32-NSRC){1'b0}}, r_pend};
      SEL_EN:  rdata = {{(32-NSRC){1'b0}}, r_enable};
      SEL_MOD: rdata = {{(32-NSRC){1'b0}}, r_mode};
      default: rdata = {27'b0, r_state, r_active_id};
    endcase
  end

  assign hwint_out = r_hwint;
  assign irq_busy  = (r_state == SERVICE);
  assign w_unused  = &{1'b0, addr[31:4], addr[1:0], wdata[31:NSRC]};

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus random traffic, all checked by a scoreboard against a reference model.
module tb_int_controller;
`ifdef INT_CTRL_SYNC_EN
  localparam int SO = 2;
`else
  localparam int SO = 0;
`endif
  localparam int HD = SO + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_in;
  logic        int_taken;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hwint_out;
  logic        irq_busy;

  always #5 clk = ~clk;

  int_controller #(.NSRC(6), .DEV_ADDR(0)) dut (
    .clk(clk), .reset(reset), .src_in(src_in), .int_taken(int_taken),
    .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .hwint_out(hwint_out), .irq_busy(irq_busy)
  );

  typedef struct packed {
    logic [5:0]  hw;
    logic        busy;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: history of sampled lines, register contents, controller phase
  bit [5:0] m_hist [HD];
  bit [5:0] m_pend, m_en, m_mode, m_hw;
  int       m_state;   // 0 idle, 1 requesting, 2 in service
  int       m_id;

  function automatic int lowest_set(input bit [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {26'b0, m_pend};
      2'd1:    return {26'b0, m_en};
      2'd2:    return {26'b0, m_mode};
      default: return {27'b0, 2'(m_state), 3'(m_id)};
    endcase
  endfunction

  task automatic model_edge();
    bit [5:0] s, sd, newp;
    int w, sel;
    if (reset) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_hw = '0; m_state = 0; m_id = 0;
      for (int k = 0; k < HD; k++) m_hist[k] = '0;
      return;
    end
    s   = m_hist[SO];
    sd  = m_hist[SO+1];
    w   = lowest_set(m_pend & m_en);
    sel = int'(addr[3:2]);
    newp = '0;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) begin
        newp[i] = m_pend[i];
        if (we && sel == 0 && wdata[i]) newp[i] = 1'b0;
        if (m_state == 1 && w == i && int_taken) newp[i] = 1'b0;
        if (s[i] && !sd[i]) newp[i] = 1'b1;
      end else begin
        newp[i] = s[i];
      end
    end
    case (m_state)
      0: begin
        m_hw = '0;
        if (w >= 0) m_state = 1;
      end
      1: begin
        if (w < 0) begin
          m_state = 0; m_hw = '0;
        end else if (int_taken) begin
          m_state = 2; m_id = w; m_hw = '0;
        end else begin
          m_hw = 6'(1 << w);
        end
      end
      default: begin
        m_hw = '0;
        if (we && sel == 3) m_state = 0;
      end
    endcase
    if (we && sel == 1) m_en   = wdata[5:0];
    if (we && sel == 2) m_mode = wdata[5:0];
    m_pend = newp;
    for (int k = HD - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = src_in;
  endtask

  // Queue the expectation for the coming negedge, then advance one clock
  task automatic step();
    exp_t e;
    e.hw   = m_hw;
    e.busy = (m_state == 2);
    e.rd   = m_rdata(addr);
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
    we = 1'b0; int_taken = 1'b0; reset = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_v);
    addr = a;
    #1;
    chk(nm, rdata, exp_v);
  endtask

  // Monitor: every negedge with a queued expectation is one scoreboard vector
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_vec++;
        if (hwint_out !== mon_e.hw || irq_busy !== mon_e.busy || rdata !== mon_e.rd) begin
          n_err++;
          $display("FAIL sb t=%0t: hw=%b busy=%b rd=0x%0h, expected hw=%b busy=%b rd=0x%0h",
                   $time, hwint_out, irq_busy, rdata, mon_e.hw, mon_e.busy, mon_e.rd);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; src_in = '0; int_taken = 1'b0; addr = '0; we = 1'b0; wdata = '0;
    for (int k = 0; k < HD; k++) m_hist[k] = '0;
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    reset = 1'b0;

    step();
    chk("reset_hw", {26'b0, hwint_out}, 32'd0);
    chk("reset_busy", {31'b0, irq_busy}, 32'd0);
    rd_chk("reset_status", 32'hC, 32'd0);

    // 1: edge on src 3 reaches hwint four clocks later
    wr(32'h4, 32'h3F);
    wr(32'h8, 32'h3F);
    src_in = 6'h08; step(); src_in = '0;
    steps(2 + SO);
    chk("t1_hw_early", {26'b0, hwint_out}, 32'd0);
    step();
    chk("t1_hw", {26'b0, hwint_out}, 32'h08);
    rd_chk("t1_pend", 32'h0, 32'h08);

    // 2: take, then EOI
    int_taken = 1'b1; step();
    chk("t2_hw", {26'b0, hwint_out}, 32'd0);
    chk("t2_busy", {31'b0, irq_busy}, 32'd1);
    rd_chk("t2_status", 32'hC, 32'h13);
    step();
    rd_chk("t2_pend", 32'h0, 32'd0);
    wr(32'hC, 32'h0);
    rd_chk("t2_status_eoi", 32'hC, 32'h03);

    // 3: simultaneous edges on 5 and 1
    src_in = 6'h22; step(); src_in = '0;
    steps(3 + SO);
    chk("t3_hw_first", {26'b0, hwint_out}, 32'h02);
    int_taken = 1'b1; step();
    wr(32'hC, 32'h0);
    step();
    chk("t3_hw_eoi1", {26'b0, hwint_out}, 32'd0);
    step();
    chk("t3_hw_second", {26'b0, hwint_out}, 32'h20);
    int_taken = 1'b1; step();
    wr(32'hC, 32'h0);

    // 4: level source re-requests after EOI, drops when the line falls
    wr(32'h8, 32'h0);
    wr(32'h4, 32'h1);
    src_in = 6'h01;
    steps(4 + SO);
    chk("t4_hw", {26'b0, hwint_out}, 32'h01);
    int_taken = 1'b1; step();
    chk("t4_busy", {31'b0, irq_busy}, 32'd1);
    wr(32'hC, 32'h0);
    steps(2);
    chk("t4_reassert", {26'b0, hwint_out}, 32'h01);
    src_in = '0;
    steps(3 + SO);
    chk("t4_drop_hw", {26'b0, hwint_out}, 32'd0);
    rd_chk("t4_drop_status", 32'hC, 32'd0);

    // 5: masked pend, late enable, W1C
    wr(32'h8, 32'h3F);
    wr(32'h4, 32'h3E);
    src_in = 6'h01; step(); src_in = '0;
    steps(3 + SO);
    chk("t5_masked_hw", {26'b0, hwint_out}, 32'd0);
    rd_chk("t5_pend", 32'h0, 32'h01);
    wr(32'h4, 32'h3F);
    step();
    chk("t5_en_hw_early", {26'b0, hwint_out}, 32'd0);
    step();
    chk("t5_en_hw", {26'b0, hwint_out}, 32'h01);
    wr(32'h0, 32'h01);
    rd_chk("t5_w1c", 32'h0, 32'd0);

    // 6: reset while in service
    src_in = 6'h04; step(); src_in = '0;
    steps(3 + SO);
    int_taken = 1'b1; step();
    chk("t6_busy_pre", {31'b0, irq_busy}, 32'd1);
    reset = 1'b1; step();
    chk("t6_hw", {26'b0, hwint_out}, 32'd0);
    chk("t6_busy", {31'b0, irq_busy}, 32'd0);
    rd_chk("t6_status", 32'hC, 32'd0);
    step();
    rd_chk("t6_pend", 32'h0, 32'd0);
    step();
    rd_chk("t6_enable", 32'h4, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      src_in    = src_in ^ 6'($urandom & $urandom & $urandom);
      int_taken = ($urandom_range(0, 3) == 0);
      addr      = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        we    = 1'b1;
        wdata = $urandom;
      end
      reset = ($urandom_range(0, 399) == 0);
      step();
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
